// File: rtl/alu_control_seq_if.sv
// Request/response bundle between the control unit and alu_control_seq.
// Port names keep the _i/_o direction suffixes as seen from the decoder.
interface alu_control_seq_if #(
    parameter int unsigned OP_WIDTH = 5
);
    logic                valid_i;
    logic                flush_i;
    logic                stall_i;
    logic [6:0]          funct7_i;
    logic [2:0]          ALU_Op_i;
    logic [2:0]          funct3_i;
    logic [OP_WIDTH-1:0] ALU_Operation_o;
    logic                valid_o;
    logic                illegal_o;
    logic                ready_o;
    logic                busy_o;
    logic                done_o;

    modport master (
        output valid_i, flush_i, stall_i, funct7_i, ALU_Op_i, funct3_i,
        input  ALU_Operation_o, valid_o, illegal_o, ready_o, busy_o, done_o
    );

    modport slave (
        input  valid_i, flush_i, stall_i, funct7_i, ALU_Op_i, funct3_i,
        output ALU_Operation_o, valid_o, illegal_o, ready_o, busy_o, done_o
    );
endinterface

// File: rtl/alu_control_seq.sv
// Registered ALU operation decoder with a multiply/divide busy sequencer.
// Define ALU_CONTROL_MEXT_EN to decode the M extension and build the sequencer.
module alu_control_seq #(
    parameter int unsigned OP_WIDTH       = 5,
    parameter int unsigned MULDIV_LATENCY = 4
) (
    input logic              clk,
    input logic              reset,
    alu_control_seq_if.slave bus
);

    if (OP_WIDTH < 5 || OP_WIDTH > 8) begin : g_bad_op_width
        $error("OP_WIDTH must be within 5..8");
    end
    if (MULDIV_LATENCY < 1 || MULDIV_LATENCY > 16) begin : g_bad_latency
        $error("MULDIV_LATENCY must be within 1..16");
    end

    localparam logic [4:0] OpAdd  = 5'd0;
    localparam logic [4:0] OpSub  = 5'd1;
    localparam logic [4:0] OpAnd  = 5'd2;
    localparam logic [4:0] OpOr   = 5'd3;
    localparam logic [4:0] OpXor  = 5'd4;
    localparam logic [4:0] OpSll  = 5'd5;
    localparam logic [4:0] OpSrl  = 5'd6;
    localparam logic [4:0] OpLui  = 5'd7;
    localparam logic [4:0] OpBeq  = 5'd8;
    localparam logic [4:0] OpBne  = 5'd9;
    localparam logic [4:0] OpSra  = 5'd10;
    localparam logic [4:0] OpSlt  = 5'd11;
    localparam logic [4:0] OpSltu = 5'd12;
    localparam logic [4:0] OpBlt  = 5'd13;
    localparam logic [4:0] OpBge  = 5'd14;
    localparam logic [4:0] OpBltu = 5'd15;
    localparam logic [4:0] OpBgeu = 5'd16;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

`ifdef ALU_CONTROL_MEXT_EN
    localparam logic [4:0] OpMul    = 5'd17;
    localparam logic [6:0] F7MulDiv = 7'b0000001;
`endif

    logic [4:0]          dec_code;
    logic                dec_illegal;
    logic                ready;
    logic                accept;
    logic                busy;
    logic                done;
    logic [OP_WIDTH-1:0] op_q;
    logic                valid_q;
    logic                illegal_q;

    always_comb begin
        dec_code    = OpAdd;
        dec_illegal = 1'b0;
        case (bus.ALU_Op_i)
            3'b000: begin
                case (bus.funct7_i)
                    F7Base: begin
                        case (bus.funct3_i)
                            3'b000:  dec_code = OpAdd;
                            3'b001:  dec_code = OpSll;
                            3'b010:  dec_code = OpSlt;
                            3'b011:  dec_code = OpSltu;
                            3'b100:  dec_code = OpXor;
                            3'b101:  dec_code = OpSrl;
                            3'b110:  dec_code = OpOr;
                            default: dec_code = OpAnd;
                        endcase
                    end
                    F7Alt: begin
                        if (bus.funct3_i == 3'b000) begin
                            dec_code = OpSub;
                        end else if (bus.funct3_i == 3'b101) begin
                            dec_code = OpSra;
                        end else begin
                            dec_illegal = 1'b1;
                        end
                    end
`ifdef ALU_CONTROL_MEXT_EN
                    F7MulDiv: dec_code = OpMul + 5'(bus.funct3_i);
`endif
                    default: dec_illegal = 1'b1;
                endcase
            end
            3'b001: begin
                // Immediate forms: funct7 only qualifies the shifts
                case (bus.funct3_i)
                    3'b000: dec_code = OpAdd;
                    3'b001: begin
                        if (bus.funct7_i == F7Base) dec_code = OpSll;
                        else                        dec_illegal = 1'b1;
                    end
                    3'b010: dec_code = OpSlt;
                    3'b011: dec_code = OpSltu;
                    3'b100: dec_code = OpXor;
                    3'b101: begin
                        if (bus.funct7_i == F7Base)     dec_code = OpSrl;
                        else if (bus.funct7_i == F7Alt) dec_code = OpSra;
                        else                            dec_illegal = 1'b1;
                    end
                    3'b110:  dec_code = OpOr;
                    default: dec_code = OpAnd;
                endcase
            end
            3'b010: dec_code = OpLui;
            3'b011: begin
                case (bus.funct3_i)
                    3'b000:  dec_code = OpBeq;
                    3'b001:  dec_code = OpBne;
                    3'b100:  dec_code = OpBlt;
                    3'b101:  dec_code = OpBge;
                    3'b110:  dec_code = OpBltu;
                    3'b111:  dec_code = OpBgeu;
                    default: dec_illegal = 1'b1;
                endcase
            end
            3'b100:  dec_code = OpAdd;
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_code = OpAdd;
        end
    end

    assign ready  = !busy && !bus.stall_i;
    assign accept = bus.valid_i && ready && !bus.flush_i;

    // Flush overrides stall; a stall freezes everything, including valid_o.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (bus.flush_i) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (!bus.stall_i) begin
            valid_q   <= accept;
            illegal_q <= accept && dec_illegal;
            if (accept) begin
                op_q <= OP_WIDTH'(dec_code);
            end
        end
    end

`ifdef ALU_CONTROL_MEXT_EN
    localparam int unsigned          CntWidth = $clog2(MULDIV_LATENCY + 1);
    localparam logic [CntWidth-1:0] CntLoad  = CntWidth'(MULDIV_LATENCY - 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                is_muldiv;

    assign is_muldiv = (dec_code >= OpMul);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // done only fires on an unstalled cycle, so a stall delays the pulse
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        if (bus.flush_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (!bus.stall_i) begin
            unique case (state_q)
                StIdle: begin
                    if (accept && is_muldiv) begin
                        state_d = StBusy;
                        cnt_d   = CntLoad;
                    end
                end
                StBusy: begin
                    if (cnt_q == '0) begin
                        done    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - CntWidth'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign busy = (state_q == StBusy);
`else
    assign busy = 1'b0;
    assign done = 1'b0;
`endif

    assign bus.ALU_Operation_o = op_q;
    assign bus.valid_o         = valid_q;
    assign bus.illegal_o       = illegal_q;
    assign bus.ready_o         = ready;
    assign bus.busy_o          = busy;
    assign bus.done_o          = done;

endmodule

// File: tb/tb_alu_control_seq.sv
// Scoreboard bench for alu_control_seq; define ALU_CONTROL_MEXT_EN to also
// exercise the multiply/divide sequencer.
module tb_alu_control_seq;

`ifdef ALU_CONTROL_MEXT_EN
    localparam bit MextEn = 1'b1;
`else
    localparam bit MextEn = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [4:0] op;
        logic       ill;
    } sb_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    sb_t  sb_q[$];

    alu_control_seq_if #(.OP_WIDTH(5)) bus ();

    alu_control_seq #(
        .OP_WIDTH      (5),
        .MULDIV_LATENCY(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Independent reference: funct3 base table plus funct7 qualifiers per class
    function automatic logic [5:0] ref_op(input logic [2:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7);
        logic [4:0] c;
        logic       bad;
        case (f3)
            3'd0:    c = 5'd0;
            3'd1:    c = 5'd5;
            3'd2:    c = 5'd11;
            3'd3:    c = 5'd12;
            3'd4:    c = 5'd4;
            3'd5:    c = 5'd6;
            3'd6:    c = 5'd3;
            default: c = 5'd2;
        endcase
        bad = 1'b0;
        case (op)
            3'd0: begin
                if (f7 == 7'h20) begin
                    if (f3 == 3'd0)      c = 5'd1;
                    else if (f3 == 3'd5) c = 5'd10;
                    else                 bad = 1'b1;
                end else if (f7 == 7'h01 && MextEn) begin
                    c = 5'd17 + 5'(f3);
                end else if (f7 != 7'h00) begin
                    bad = 1'b1;
                end
            end
            3'd1: begin
                if (f3 == 3'd1 && f7 != 7'h00)                    bad = 1'b1;
                else if (f3 == 3'd5 && f7 == 7'h20)               c = 5'd10;
                else if (f3 == 3'd5 && f7 != 7'h00)               bad = 1'b1;
            end
            3'd2: c = 5'd7;
            3'd3: begin
                case (f3)
                    3'd0:    c = 5'd8;
                    3'd1:    c = 5'd9;
                    3'd4:    c = 5'd13;
                    3'd5:    c = 5'd14;
                    3'd6:    c = 5'd15;
                    3'd7:    c = 5'd16;
                    default: bad = 1'b1;
                endcase
            end
            3'd4:    c = 5'd0;
            default: bad = 1'b1;
        endcase
        if (bad) c = 5'd0;
        return {bad, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.valid_i = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // One-cycle request; expectation queued only if the DUT should accept it
    task automatic req(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7);
        logic [5:0] r;
        sb_t        e;
        r = ref_op(op, f3, f7);
        bus.valid_i  = 1'b1;
        bus.ALU_Op_i = op;
        bus.funct3_i = f3;
        bus.funct7_i = f7;
        if (!bus.stall_i && !bus.flush_i) begin
            e.cyc = cyc + 1;
            e.op  = r[4:0];
            e.ill = r[5];
            sb_q.push_back(e);
        end
        tick();
    endtask

    logic       exp_v, exp_ill, stall_prev, flush_prev;
    logic [4:0] exp_op;

    always @(negedge clk) begin
        sb_t e;
        if (!mon_en) begin
            sb_q.delete();
            exp_v      = 1'b0;
            exp_ill    = 1'b0;
            exp_op     = 5'd0;
            stall_prev = 1'b0;
            flush_prev = 1'b0;
        end else begin
            // A stalled (unflushed) cycle holds the previous outputs
            if (!(stall_prev && !flush_prev)) begin
                if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                    e       = sb_q.pop_front();
                    exp_v   = 1'b1;
                    exp_op  = e.op;
                    exp_ill = e.ill;
                end else begin
                    exp_v   = 1'b0;
                    exp_ill = 1'b0;
                end
            end
            check_eq("valid_o", bus.valid_o, exp_v);
            check_eq("illegal_o", bus.illegal_o, exp_ill);
            if (exp_v) check_eq("ALU_Operation_o", bus.ALU_Operation_o, exp_op);
`ifndef ALU_CONTROL_MEXT_EN
            check_eq("busy_o_tied", bus.busy_o, 1'b0);
            check_eq("done_o_tied", bus.done_o, 1'b0);
            check_eq("ready_o", bus.ready_o, !bus.stall_i);
`endif
            stall_prev = bus.stall_i;
            flush_prev = bus.flush_i;
        end
    end

`ifdef ALU_CONTROL_MEXT_EN
    // Bit k of each mask is the value for cycle N+k, where N is the accept cycle
    task automatic mdiv_seq(input string tag, input logic [2:0] f3, input int n,
                            input logic [15:0] busy_e, input logic [15:0] done_e,
                            input logic [15:0] stall_e, input logic [15:0] flush_e,
                            input logic [15:0] rst_e);
        sb_t        e;
        logic [5:0] r;
        r = ref_op(3'd0, f3, 7'h01);
        for (int k = 0; k < n; k++) begin
            bus.ALU_Op_i = 3'd0;
            bus.funct7_i = (k == 0) ? 7'h01 : 7'h00;
            bus.funct3_i = (k == 0) ? f3 : 3'd0;
            bus.valid_i  = (k == 0) || (k == 2);
            bus.stall_i  = stall_e[k];
            bus.flush_i  = flush_e[k];
            if (k == 0) begin
                e.cyc = cyc + 1;
                e.op  = r[4:0];
                e.ill = r[5];
                sb_q.push_back(e);
            end
            @(negedge clk);
            check_eq({tag, "_busy"}, bus.busy_o, busy_e[k]);
            check_eq({tag, "_done"}, bus.done_o, done_e[k]);
            check_eq({tag, "_ready"}, bus.ready_o, !busy_e[k] && !stall_e[k]);
            if (busy_e[k]) check_eq({tag, "_hold_op"}, bus.ALU_Operation_o, r[4:0]);
            if (rst_e[k]) begin
                #1 reset = 1'b1;
            end
            tick();
            reset = 1'b0;
        end
        bus.valid_i = 1'b0;
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        bus.valid_i  = 1'b0;
        bus.flush_i  = 1'b0;
        bus.stall_i  = 1'b0;
        bus.ALU_Op_i = 3'd0;
        bus.funct3_i = 3'd0;
        bus.funct7_i = 7'd0;
        #3;
        check_eq("rst_op", bus.ALU_Operation_o, 0);
        check_eq("rst_valid", bus.valid_o, 0);
        check_eq("rst_illegal", bus.illegal_o, 0);
        check_eq("rst_busy", bus.busy_o, 0);
        check_eq("rst_done", bus.done_o, 0);
        check_eq("rst_ready", bus.ready_o, 1);
        tick();
        tick();
        reset  = 1'b0;
        mon_en = 1'b1;

        req(3'd0, 3'd0, 7'h20);             // SUB
        req(3'd1, 3'd5, 7'h20);             // SRAI
        req(3'd1, 3'd1, 7'h20);             // SLLI with bad funct7
        req(3'd3, 3'd2, 7'h00);             // branch funct3 010 illegal
        req(3'd2, 3'd6, 7'h7f);             // LUI ignores fields
`ifndef ALU_CONTROL_MEXT_EN
        req(3'd0, 3'd4, 7'h01);             // DIV without M extension
`endif
        idle(2);

        for (int op = 0; op < 8; op++) begin
            for (int f3 = 0; f3 < 8; f3++) begin
                for (int j = 0; j < 4; j++) begin
                    logic [6:0] f7;
                    logic [5:0] r;
                    case (j)
                        0:       f7 = 7'h00;
                        1:       f7 = 7'h20;
                        2:       f7 = 7'h01;
                        default: f7 = 7'($urandom_range(0, 127));
                    endcase
                    r = ref_op(3'(op), 3'(f3), f7);
                    if (!(MextEn && !r[5] && r[4:0] >= 5'd17)) begin
                        req(3'(op), 3'(f3), f7);
                    end
                end
            end
        end
        idle(2);

        // Stall: second request refused, first result held for the stalled cycle
        req(3'd0, 3'd4, 7'h00);
        bus.stall_i = 1'b1;
        req(3'd0, 3'd6, 7'h00);
        bus.stall_i = 1'b0;
        idle(3);

        // Flush drops a same-cycle request and beats a concurrent stall
        bus.flush_i = 1'b1;
        req(3'd0, 3'd0, 7'h00);
        bus.flush_i = 1'b0;
        idle(1);
        req(3'd5, 3'd0, 7'h00);
        bus.valid_i = 1'b0;
        bus.stall_i = 1'b1;
        bus.flush_i = 1'b1;
        tick();
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        idle(3);

        // Asynchronous reset mid-cycle clears a live BGEU result
        req(3'd3, 3'd7, 7'h00);
        bus.valid_i = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check_eq("async_rst_op", bus.ALU_Operation_o, 0);
        check_eq("async_rst_valid", bus.valid_o, 0);
        check_eq("async_rst_ready", bus.ready_o, 1);
        tick();
        reset = 1'b0;
        idle(2);

`ifdef ALU_CONTROL_MEXT_EN
        mdiv_seq("div", 3'd4, 6, 16'h001E, 16'h0010, 16'h0000, 16'h0000, 16'h0000);
        idle(1);
        mdiv_seq("div_stall", 3'd4, 8, 16'h007E, 16'h0040, 16'h000C, 16'h0000, 16'h0000);
        idle(1);
        mdiv_seq("mul_flush", 3'd0, 5, 16'h0006, 16'h0000, 16'h0000, 16'h0004, 16'h0000);
        idle(1);
        mdiv_seq("mul_reset", 3'd0, 5, 16'h0006, 16'h0000, 16'h0000, 16'h0000, 16'h0004);
        idle(4);
`endif

        check_eq("sb_drain", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_control_seq.md
ALU_CONTROL_SEQ -- requirements
Module: alu_control_seq

Interface
REQ-001 SHALL have parameter OP_WIDTH, default 5, ALU operation code width (legal range 5..8; codes zero-extended).
REQ-002 SHALL have parameter MULDIV_LATENCY, default 4, cycles a multiply/divide operation holds busy (legal range 1..16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports valid_i  input  1  decode request; flush_i  input  1  discard pipeline contents; stall_i  input  1  hold outputs and counter.
REQ-006 SHALL have ports funct7_i  input  7, ALU_Op_i  input  3, funct3_i  input  3  instruction fields from control unit/instruction bus.
REQ-007 SHALL have ports ALU_Operation_o  output  OP_WIDTH  registered op code; valid_o  output  1  op code valid; illegal_o  output  1  unmatched selector.
REQ-008 SHALL have ports ready_o  output  1  request accepted; busy_o  output  1  mul/div in progress; done_o  output  1  one-cycle mul/div completion pulse.

Function
REQ-009 ALU_Op_i decode SHALL be: 000 R-type, 001 I-type arithmetic, 010 LUI, 011 branch, 100 address add (load/store/JAL); 101..111 illegal.
REQ-010 Op codes SHALL be: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, LUI 7, BEQ 8, BNE 9, SRA 10, SLT 11, SLTU 12, BLT 13, BGE 14, BLTU 15, BGEU 16, MUL 17, MULH 18, MULHSU 19, MULHU 20, DIV 21, DIVU 22, REM 23, REMU 24.
REQ-011 R-type SHALL decode funct7 0000000/0100000 per RV32I (0100000 only with funct3 000 SUB, 101 SRA); I-type SHALL ignore funct7 except shifts (funct3 001 SLLI needs 0000000; 101 needs 0000000 SRLI or 0100000 SRAI); I-type funct3 010/011 SHALL give SLT/SLTU; LUI and address add SHALL ignore funct3/funct7; branch funct3 010/011 illegal.
REQ-012 Unmatched selector SHALL register ALU_Operation_o=0 (ADD) with illegal_o=1 alongside valid_o.
REQ-013 ready_o SHALL equal !busy_o && !stall_i (combinational); request accepted when valid_i && ready_o && !flush_i.
REQ-014 Accepted request in cycle N SHALL present ALU_Operation_o, illegal_o, valid_o=1 in cycle N+1 (latency 1); without an accept valid_o SHALL be 0 next cycle unless stalled.
REQ-015 FSM states IDLE, BUSY: accepted mul/div op (codes 17..24) SHALL move IDLE->BUSY, load counter with MULDIV_LATENCY-1, assert busy_o from N+1 through N+MULDIV_LATENCY inclusive.
REQ-016 In BUSY counter SHALL decrement each unstalled cycle; at count 0 done_o=1 for that cycle and FSM returns IDLE next cycle; MULDIV_LATENCY=1 SHALL give busy_o and done_o in N+1 only.
REQ-017 ALU_Operation_o SHALL hold the mul/div code for the whole BUSY period; valid_o SHALL be 1 only in N+1.
REQ-018 stall_i=1 SHALL freeze all registered outputs, counter and FSM state; done_o SHALL not repeat after stall release (pulse is delayed, not duplicated).
REQ-019 flush_i=1 SHALL clear valid_o, illegal_o, busy_o next cycle, force IDLE, suppress done_o, and drop a same-cycle valid_i; flush_i SHALL win over stall_i.
REQ-020 Counter width SHALL be $clog2(MULDIV_LATENCY+1) bits; no wrap below 0.

Reset
REQ-021 reset SHALL asynchronously force ALU_Operation_o=0, valid_o=0, illegal_o=0, busy_o=0, done_o=0, counter=0, FSM=IDLE; ready_o SHALL read 1 while reset held (stall_i=0).
REQ-022 Reset mid-BUSY SHALL abort the operation with no done_o pulse after release.

Configuration
REQ-023 With macro ALU_CONTROL_MEXT_EN defined, funct7 0000001 under R-type SHALL decode MUL..REMU (codes 17..24) with the BUSY sequencer.
REQ-024 Without ALU_CONTROL_MEXT_EN, funct7 0000001 SHALL decode as illegal (code 0, illegal_o=1), busy_o and done_o SHALL be tied 0, and no FSM/counter SHALL be synthesised.

Verification
REQ-025 R-type funct7=0100000, funct3=000, ALU_Op=000, valid_i at N -> ALU_Operation_o=1, valid_o=1 at N+1, illegal_o=0.
REQ-026 I-type funct3=101 funct7=0100000 -> code 10 (SRA); I-type funct3=001 funct7=0100000 -> code 0, illegal_o=1.
REQ-027 MEXT_EN, MULDIV_LATENCY=4, DIV (funct7=0000001, funct3=100) at N -> busy_o N+1..N+4, done_o at N+4 only, ready_o low N+1..N+4, second valid_i at N+2 ignored.
REQ-028 Same as REQ-027 with stall_i high N+2..N+3 -> busy_o through N+6, single done_o at N+6.
REQ-029 MUL accepted at N, flush_i at N+2 -> busy_o=0 at N+3, done_o never asserted; reset at N+2 instead gives identical outputs.
REQ-030 MEXT_EN undefined, funct7=0000001 R-type -> code 0, illegal_o=1, busy_o stays 0, ready_o stays 1.
